mux_key_rev: RTL and testbench
==============================

Name: mux_key_rev

Overview:
- Reverse-lookup companion to the key-to-data LUT mux: holds a writable table of NR_KEY (key, data) pairs and, given a data value, returns the matching key and its table index.
- Used where a decoded value must be mapped back to its selector code, e.g. opcode/funct recovery and trace/debug reverse mapping.
- Registered table with valid bits; single-cycle write port; one-deep registered query pipeline with valid/ready backpressure.

Parameters:
- NR_KEY, 4, number of table entries (>=2).
- KEY_LEN, 4, key width in bits.
- DATA_LEN, 8, data width in bits.
- IDX_LEN (localparam), $clog2(NR_KEY), entry index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous invalidate of all entries.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_LEN  entry to write.
- wr_key  in  KEY_LEN  key stored.
- wr_data  in  DATA_LEN  data stored.
- default_key  in  KEY_LEN  key returned on miss.
- q_valid  in  1  query present.
- q_ready  out  1  query accepted when q_valid&&q_ready.
- q_data  in  DATA_LEN  data value to search.
- r_valid  out  1  result present.
- r_ready  in  1  result consumed when r_valid&&r_ready.
- r_hit  out  1  at least one valid entry matched.
- r_multi  out  1  more than one valid entry matched.
- r_key  out  KEY_LEN  matched key, or default_key on miss.
- r_idx  out  IDX_LEN  matched index, 0 on miss.

Behaviour:
- Reset (rst_n low, async): all entry valid bits 0; r_valid=0, r_hit=0, r_multi=0, r_key=0, r_idx=0. Key/data storage need not reset.
- Write: on a rising edge with wr_en=1, entry[wr_idx] takes {wr_key, wr_data} and its valid bit is set. wr_idx>=NR_KEY is ignored. Writes are always accepted; there is no write handshake.
- clr: on a rising edge, clears every valid bit. If clr and wr_en are both high, clr wins and the write is dropped. clr does not affect an already-registered result.
- Match: entry i matches when valid[i] && data[i]==q_data.
- Priority: the lowest matching index wins. r_multi = popcount(matches)>1.
- Miss: r_hit=0, r_key=default_key (sampled in the accept cycle), r_idx=0.
- Latency: a query accepted at edge N has its result registered at edge N and visible as r_valid=1 in cycle N+1. r_valid and all r_* fields are held stable until r_ready.
- Backpressure: q_ready = !r_valid || r_ready (combinational). Throughput is one query per cycle when r_ready stays high.
- Same-cycle write/clr and query: the compare uses table contents before the edge (old value). The write or clr becomes visible to queries accepted on the next edge.
- A result is dropped from r_valid only on r_ready. When r_ready is high and no new query is accepted, r_valid goes to 0 next cycle.
- Async reset mid-transaction: the pending result is discarded (r_valid=0) and the table is invalidated.
- No combinational path from q_data to the r_* outputs.

Decomposition:
- No package needed. IDX_LEN and the pair layout stay local.
- One natural sub-module: mux_key_prio_enc. Parameter N; input match vector [N-1:0]; outputs found, multi, idx (lowest set bit). Purely combinational; instantiated once.

Test Plan:
- Reset, then query q_data=8'h55 with default_key=4'hF -> cycle+1: r_valid=1, r_hit=0, r_key=4'hF, r_idx=0, r_multi=0.
- Write idx1 {4'h3, 8'hA0} and idx2 {4'h7, 8'hB0}; query 8'hB0 -> r_hit=1, r_key=4'h7, r_idx=2.
- Write idx0 {4'h9, 8'hA0}; query 8'hA0 -> r_key=4'h9, r_idx=0, r_multi=1 (idx0 beats idx1).
- Hold r_ready=0 with a result pending, keep q_valid=1 -> q_ready=0 and r_* stable for 5 cycles. Raise r_ready -> next query is accepted in the same cycle; back-to-back results arrive one per cycle.
- Same cycle: wr_en idx3 {4'h5, 8'hC0} and query 8'hC0 -> miss (old table). Repeat the query next cycle -> hit, r_key=4'h5. Pulse clr together with wr_en -> subsequent query 8'hC0 misses.
- Assert rst_n low while r_valid=1 -> r_valid=0 immediately. After release, query 8'hB0 -> miss.

Source files
------------

// File: rtl/mux_key_prio_enc.sv
// rtl/mux_key_prio_enc.sv - lowest-index priority encoder with multi-hit flag
module mux_key_prio_enc #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_match,
  output logic             o_found,
  output logic             o_multi,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_found = |i_match;
    // clearing the lowest set bit leaves something only if two or more were set
    o_multi = |(i_match & (i_match - N'(1)));
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_match[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mux_key_rev.sv
// rtl/mux_key_rev.sv - reverse key lookup: data value to (key, index) with registered result
module mux_key_rev #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  localparam int IDX_LEN = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [KEY_LEN-1:0]  default_key,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [DATA_LEN-1:0] q_data,
  output logic                r_valid,
  input  logic                r_ready,
  output logic                r_hit,
  output logic                r_multi,
  output logic [KEY_LEN-1:0]  r_key,
  output logic [IDX_LEN-1:0]  r_idx
);

  logic [NR_KEY-1:0]   r_tab_valid;
  logic [KEY_LEN-1:0]  r_tab_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_tab_data [NR_KEY];

  logic                r_out_valid;
  logic                r_out_hit;
  logic                r_out_multi;
  logic [KEY_LEN-1:0]  r_out_key;
  logic [IDX_LEN-1:0]  r_out_idx;

  logic [NR_KEY-1:0]   w_match;
  logic                w_found;
  logic                w_multi;
  logic [IDX_LEN-1:0]  w_idx;
  logic                w_accept;

  assign q_ready  = !r_out_valid || r_ready;
  assign w_accept = q_valid && q_ready;

  // an out-of-range wr_idx matches no entry, so the write falls away naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tab_valid <= '0;
    end else if (clr) begin
      r_tab_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) r_tab_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) begin
          r_tab_key[i]  <= wr_key;
          r_tab_data[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_match[i] = r_tab_valid[i] && (r_tab_data[i] == q_data);
    end
  end

  mux_key_prio_enc #(.N(NR_KEY)) u_prio_enc (
    .i_match (w_match),
    .o_found (w_found),
    .o_multi (w_multi),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_multi <= 1'b0;
      r_out_key   <= '0;
      r_out_idx   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_hit   <= w_found;
      r_out_multi <= w_multi;
      r_out_key   <= w_found ? r_tab_key[w_idx] : default_key;
      r_out_idx   <= w_found ? w_idx : '0;
    end else if (r_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign r_valid = r_out_valid;
  assign r_hit   = r_out_hit;
  assign r_multi = r_out_multi;
  assign r_key   = r_out_key;
  assign r_idx   = r_out_idx;

endmodule

// File: tb/tb_mux_key_rev.sv
// tb/tb_mux_key_rev.sv - directed vector bench for mux_key_rev
module tb_mux_key_rev;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic [7:0] wr_data;
  logic [3:0] default_key;
  logic       q_valid;
  logic       q_ready;
  logic [7:0] q_data;
  logic       r_valid;
  logic       r_ready;
  logic       r_hit;
  logic       r_multi;
  logic [3:0] r_key;
  logic [1:0] r_idx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       do_wr;
    logic [1:0] w_idx;
    logic [3:0] w_key;
    logic [7:0] w_data;
    logic [7:0] qd;
    logic [3:0] dk;
    logic       e_hit;
    logic       e_multi;
    logic [3:0] e_key;
    logic [1:0] e_idx;
  } vec_t;

  vec_t vecs [6];

  mux_key_rev #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_key      (wr_key),
    .wr_data     (wr_data),
    .default_key (default_key),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_data      (q_data),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_hit       (r_hit),
    .r_multi     (r_multi),
    .r_key       (r_key),
    .r_idx       (r_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input logic h, input logic m,
                           input logic [3:0] k, input logic [1:0] ix);
    check({tag, ".r_valid"}, 32'(r_valid), 32'(v));
    check({tag, ".r_hit"},   32'(r_hit),   32'(h));
    check({tag, ".r_multi"}, 32'(r_multi), 32'(m));
    check({tag, ".r_key"},   32'(r_key),   32'(k));
    check({tag, ".r_idx"},   32'(r_idx),   32'(ix));
  endtask

  task automatic write(input logic [1:0] ix, input logic [3:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = ix; wr_key = k; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h55, 4'hF, 1'b0, 1'b0, 4'hF, 2'd0};
    vecs[1] = '{1'b1, 2'd1, 4'h3, 8'hA0, 8'hA0, 4'hF, 1'b1, 1'b0, 4'h3, 2'd1};
    vecs[2] = '{1'b1, 2'd2, 4'h7, 8'hB0, 8'hB0, 4'hF, 1'b1, 1'b0, 4'h7, 2'd2};
    vecs[3] = '{1'b1, 2'd0, 4'h9, 8'hA0, 8'hA0, 4'hF, 1'b1, 1'b1, 4'h9, 2'd0};
    vecs[4] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h12, 4'hA, 1'b0, 1'b0, 4'hA, 2'd0};
    vecs[5] = '{1'b1, 2'd3, 4'h5, 8'hD0, 8'hD0, 4'h2, 1'b1, 1'b0, 4'h5, 2'd3};

    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
    default_key = 4'hF; q_valid = 1'b0; q_data = '0; r_ready = 1'b1;
    tick(); tick();
    check_res("reset", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wr) write(vecs[i].w_idx, vecs[i].w_key, vecs[i].w_data);
      q_valid = 1'b1; q_data = vecs[i].qd; default_key = vecs[i].dk;
      check($sformatf("v%0d.q_ready", i), 32'(q_ready), 32'd1);
      tick();
      q_valid = 1'b0; default_key = 4'h0;
      check_res($sformatf("v%0d", i), 1'b1, vecs[i].e_hit, vecs[i].e_multi,
                vecs[i].e_key, vecs[i].e_idx);
      tick();
      check($sformatf("v%0d.drain", i), 32'(r_valid), 32'd0);
    end

    // backpressure: result held while r_ready is low
    default_key = 4'hF; r_ready = 1'b0;
    q_valid = 1'b1; q_data = 8'hB0;
    tick();
    q_data = 8'hA0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp%0d.q_ready", c), 32'(q_ready), 32'd0);
      check_res($sformatf("bp%0d", c), 1'b1, 1'b1, 1'b0, 4'h7, 2'd2);
    end
    r_ready = 1'b1;
    #1;
    check("bp.q_ready_release", 32'(q_ready), 32'd1);
    tick();
    check_res("b2b0", 1'b1, 1'b1, 1'b1, 4'h9, 2'd0);
    q_data = 8'hD0;
    tick();
    check_res("b2b1", 1'b1, 1'b1, 1'b0, 4'h5, 2'd3);
    q_data = 8'h55;
    tick();
    check_res("b2b2", 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
    q_valid = 1'b0;
    tick();
    check("b2b.drain", 32'(r_valid), 32'd0);

    // write and query on the same edge sees the old table
    wr_en = 1'b1; wr_idx = 2'd3; wr_key = 4'h5; wr_data = 8'hC0;
    q_valid = 1'b1; q_data = 8'hC0;
    tick();
    wr_en = 1'b0;
    check_res("samecyc.old", 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
    tick();
    check_res("samecyc.new", 1'b1, 1'b1, 1'b0, 4'h5, 2'd3);
    q_valid = 1'b0;
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd2; wr_key = 4'h7; wr_data = 8'hC0;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    check("clr.keeps_drop", 32'(r_valid), 32'd0);
    q_valid = 1'b1; q_data = 8'hC0;
    tick();
    check_res("clr.miss", 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
    q_data = 8'hA0;
    tick();
    q_valid = 1'b0;
    check_res("clr.miss2", 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
    tick();

    // async reset discards a pending result and empties the table
    write(2'd2, 4'h7, 8'hB0);
    r_ready = 1'b0; q_valid = 1'b1; q_data = 8'hB0;
    tick();
    q_valid = 1'b0;
    check_res("prereset", 1'b1, 1'b1, 1'b0, 4'h7, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_res("async_rst", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    tick();
    rst_n = 1'b1; r_ready = 1'b1;
    tick();
    q_valid = 1'b1; q_data = 8'hB0;
    tick();
    q_valid = 1'b0;
    check_res("postreset", 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
